alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 32-bit ALU between two requesters, e.g. the main datapath (req0) and the branch/jump resolution unit (req1). Uses round-robin arbitration, a valid/ready request handshake, registered operand issue, and a registered, held response. The block sits between the requesters and the ALU. It drives the ALU operand/opcode inputs from registers and captures the ALU's Result/Zero/isJR outputs.

Parameters:
DATA_WIDTH, 32, width of A, B, rs and result
SHAMT_WIDTH, 5, shift-amount width
OP_WIDTH, 4, ALU operation code width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
reqN_valid  input  1  (N=0,1) requester N has an operation
reqN_ready  output  1  arbiter accepts requester N this cycle
reqN_op  input  OP_WIDTH  ALU operation code
reqN_a / reqN_b / reqN_rs  input  DATA_WIDTH  operands
reqN_shamt  input  SHAMT_WIDTH  shift amount
alu_op  output  OP_WIDTH  to ALU ALUOperation
alu_a / alu_b / alu_rs  output  DATA_WIDTH  to ALU A/B/rs
alu_shamt  output  SHAMT_WIDTH  to ALU shamt
alu_result  input  DATA_WIDTH  from ALU ALUResult
alu_zero  input  1  from ALU Zero
alu_isjr  input  1  from ALU isJR
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued the response (0/1)
rsp_result  output  DATA_WIDTH  captured ALU result
rsp_zero  output  1  captured Zero
rsp_isjr  output  1  captured isJR

Behaviour:
- One clock, clk. reset is asynchronous and active-low; all state clears immediately on reset low.
- Reset values:
  - state=IDLE, priority pointer=0 (req0 favoured).
  - alu_op/alu_a/alu_b/alu_rs/alu_shamt=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_isjr=0.
  - req0_ready=req1_ready=0.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - Grant = the valid requester if only one is valid.
  - If both are valid, grant = the requester the priority pointer names.
  - reqN_ready is combinational and equals (state==IDLE) & reqN_valid & (grant==N). At most one ready is high in any cycle.
  - On the handshake, register that requester's op/a/b/rs/shamt into the alu_* outputs, latch the id, and go to ISSUE.
  - With no valid request, stay in IDLE; alu_* hold their last values.
- ISSUE (exactly 1 cycle):
  - The ALU is combinational, so alu_* are stable for the whole cycle.
  - At the clock edge, capture alu_result/alu_zero/alu_isjr into rsp_result/rsp_zero/rsp_isjr, set rsp_valid=1, rsp_id=latched id, and go to HOLD.
- HOLD:
  - rsp_* are held stable while rsp_ready=0 (unbounded stall allowed). No request is accepted.
  - On rsp_valid & rsp_ready: clear rsp_valid, set priority pointer = ~rsp_id, return to IDLE.
- Latency: handshake in cycle T gives rsp_valid high from T+2. Minimum issue interval is 3 cycles per operation.
- The opcode is passed through unmodified; the arbiter never decodes it. Result/Zero/isJR semantics, including shared encodings, are the ALU's.
- Requester rule: valid and payload stay stable until ready. Dropping valid without ready is legal and simply withdraws the request.
- Simultaneous events:
  - Both requesters valid in IDLE: the pointer decides.
  - A new request arriving in HOLD waits.
  - rsp_ready high while rsp_valid=0 is ignored.
- Reset mid-operation (ISSUE or HOLD): the in-flight operation is discarded and no response is produced. After release, the block is in IDLE with pointer=0.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. Neither requester waits more than one other operation.

Test Plan:
- Reset release; req0 only, op=0011, A=5, B=3, rsp_ready=1 -> req0_ready pulses 1 cycle; rsp_valid 2 cycles later; rsp_result=8, rsp_zero=0, rsp_id=0; back to IDLE.
- req0 and req1 valid in the same cycle right after reset, rsp_ready=1 -> req0 served first, then req1; rsp_id sequence 0,1; req1_ready never high while state!=IDLE.
- Both requesters held valid for 8 operations -> rsp_id alternates 0,1,0,1,0,1,0,1; a new request is accepted every 3 cycles.
- req1 op=1000, A=7, rs=7 -> rsp_result=7, rsp_zero=1. Then op=1001, A=0x40 -> rsp_result=0x40, rsp_isjr=1.
- rsp_ready held low 5 cycles in HOLD with req0 valid -> rsp_* unchanged and req0_ready=0 throughout. After rsp_ready=1, req0 is accepted next IDLE cycle.
- Assert reset during ISSUE -> rsp_valid=0 and alu_*=0 immediately, no response emitted. After release, a simultaneous req0/req1 request is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are issued from registers; the ALU outputs are captured into a held response.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int OP_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [OP_WIDTH-1:0]    req0_op,
    input  logic [DATA_WIDTH-1:0]  req0_a,
    input  logic [DATA_WIDTH-1:0]  req0_b,
    input  logic [DATA_WIDTH-1:0]  req0_rs,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [OP_WIDTH-1:0]    req1_op,
    input  logic [DATA_WIDTH-1:0]  req1_a,
    input  logic [DATA_WIDTH-1:0]  req1_b,
    input  logic [DATA_WIDTH-1:0]  req1_rs,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [DATA_WIDTH-1:0]  alu_rs,
    output logic [SHAMT_WIDTH-1:0] alu_shamt,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_zero,
    input  logic                   alu_isjr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DATA_WIDTH-1:0]  rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_isjr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   ptr_r;
    logic   id_r;
    logic   grant_s;
    logic   accept_s;
    logic   consume_s;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ptr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    assign req0_ready = reset & (state_r == IDLE) & req0_valid & ~grant_s;
    assign req1_ready = reset & (state_r == IDLE) & req1_valid &  grant_s;
    assign accept_s   = req0_ready | req1_ready;
    assign consume_s  = (state_r == HOLD) & rsp_valid & rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = HOLD;
            HOLD: begin
                if (consume_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand issue, response capture and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op     <= {OP_WIDTH{1'b0}};
            alu_a      <= {DATA_WIDTH{1'b0}};
            alu_b      <= {DATA_WIDTH{1'b0}};
            alu_rs     <= {DATA_WIDTH{1'b0}};
            alu_shamt  <= {SHAMT_WIDTH{1'b0}};
            id_r       <= 1'b0;
            ptr_r      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= {DATA_WIDTH{1'b0}};
            rsp_zero   <= 1'b0;
            rsp_isjr   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r <= grant_s;
                        if (grant_s) begin
                            alu_op    <= req1_op;
                            alu_a     <= req1_a;
                            alu_b     <= req1_b;
                            alu_rs    <= req1_rs;
                            alu_shamt <= req1_shamt;
                        end else begin
                            alu_op    <= req0_op;
                            alu_a     <= req0_a;
                            alu_b     <= req0_b;
                            alu_rs    <= req0_rs;
                            alu_shamt <= req0_shamt;
                        end
                    end
                end
                ISSUE: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_r;
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_isjr   <= alu_isjr;
                end
                HOLD: begin
                    // The requester just served loses the next tie.
                    if (consume_s) begin
                        rsp_valid <= 1'b0;
                        ptr_r     <= ~rsp_id;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, transaction-level reference model
// checked every cycle, plus hand-computed response expectations.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int OW = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OW-1:0] req0_op, req1_op, alu_op;
    logic [DW-1:0] req0_a, req0_b, req0_rs, req1_a, req1_b, req1_rs;
    logic [SW-1:0] req0_shamt, req1_shamt, alu_shamt;
    logic [DW-1:0] alu_a, alu_b, alu_rs, alu_result, rsp_result;
    logic          alu_zero, alu_isjr;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_isjr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int id_log[$];
    int hs_log[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .OP_WIDTH(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_rs(req0_rs), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_rs(req1_rs), .req1_shamt(req1_shamt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_rs(alu_rs), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_isjr(alu_isjr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_isjr(rsp_isjr)
    );

    // Small ALU: returns {isjr, zero, result}.
    function automatic logic [DW+1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] rs,
                                            input logic [SW-1:0] sh);
        logic [DW-1:0] r;
        logic          z;
        logic          j;
        r = '0;
        j = 1'b0;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a - b;
            4'd3:    r = a + b;
            4'd4:    r = b << sh;
            4'd8:    r = a;
            4'd9:    begin r = a; j = 1'b1; end
            default: r = '0;
        endcase
        z = (op == 4'd8) ? (a == rs) : (r == '0);
        return {j, z, r};
    endfunction

    assign {alu_isjr, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b, alu_rs, alu_shamt);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: at most one operation in flight; age counts edges since its handshake.
    bit            m_inflight = 1'b0;
    int            m_age      = 0;
    logic          m_ptr = 1'b0, m_id = 1'b0;
    logic          m_rsp_id = 1'b0, m_rsp_zero = 1'b0, m_rsp_isjr = 1'b0;
    logic [DW-1:0] m_rsp_result = '0, m_a = '0, m_b = '0, m_rs = '0;
    logic [OW-1:0] m_op = '0;
    logic [SW-1:0] m_sh = '0;
    logic          m_g, m_e0, m_e1, m_erv;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            m_inflight = 1'b0; m_age = 0; m_ptr = 1'b0; m_id = 1'b0;
            m_rsp_id = 1'b0; m_rsp_zero = 1'b0; m_rsp_isjr = 1'b0; m_rsp_result = '0;
            m_op = '0; m_a = '0; m_b = '0; m_rs = '0; m_sh = '0;
            chk("reset_ready0", 64'(req0_ready), 64'd0);
            chk("reset_ready1", 64'(req1_ready), 64'd0);
            chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("reset_alu_a", 64'(alu_a), 64'd0);
            chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        end else begin
            m_g   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            m_e0  = !m_inflight && req0_valid && !m_g;
            m_e1  = !m_inflight && req1_valid && m_g;
            m_erv = m_inflight && (m_age >= 1);
            chk("req0_ready", 64'(req0_ready), 64'(m_e0));
            chk("req1_ready", 64'(req1_ready), 64'(m_e1));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_erv));
            chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
            chk("rsp_result", 64'(rsp_result), 64'(m_rsp_result));
            chk("rsp_zero", 64'(rsp_zero), 64'(m_rsp_zero));
            chk("rsp_isjr", 64'(rsp_isjr), 64'(m_rsp_isjr));
            chk("alu_op", 64'(alu_op), 64'(m_op));
            chk("alu_a", 64'(alu_a), 64'(m_a));
            chk("alu_b", 64'(alu_b), 64'(m_b));
            chk("alu_rs", 64'(alu_rs), 64'(m_rs));
            chk("alu_shamt", 64'(alu_shamt), 64'(m_sh));
            if (m_inflight) begin
                if (m_erv && rsp_ready) begin
                    m_inflight = 1'b0;
                    m_ptr      = ~m_rsp_id;
                end else if (m_age == 0) begin
                    {m_rsp_isjr, m_rsp_zero, m_rsp_result} = alu_f(m_op, m_a, m_b, m_rs, m_sh);
                    m_rsp_id = m_id;
                    m_age    = 1;
                end
            end else if (m_e0 || m_e1) begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_id       = m_e1;
                if (m_e1) begin
                    m_op = req1_op; m_a = req1_a; m_b = req1_b; m_rs = req1_rs; m_sh = req1_shamt;
                end else begin
                    m_op = req0_op; m_a = req0_a; m_b = req0_b; m_rs = req0_rs; m_sh = req0_shamt;
                end
            end
        end
    end

    // Transaction log for ordering and issue-interval checks.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) id_log.push_back(int'(rsp_id));
        if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) hs_log.push_back(cyc);
    end

    task automatic send(input logic n, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] rs, input logic [SW-1:0] sh);
        logic hs;
        hs = 1'b0;
        if (n) begin
            req1_op = op; req1_a = a; req1_b = b; req1_rs = rs; req1_shamt = sh; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_rs = rs; req0_shamt = sh; req0_valid = 1'b1;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            hs = n ? req1_ready : req0_ready;
            @(posedge clk);
            #2;
            if (hs) break;
        end
        if (n) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: requester %0d got no ready, required one within 100 cycles", n);
        end
    endtask

    task automatic wait_rsp(input logic id, input logic [DW-1:0] res, input logic z, input logic j);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cnt++;
            if (rsp_valid) break;
        end
        chk("lit_latency", 64'(cnt), 64'd2);
        chk("lit_rsp_id", 64'(rsp_id), 64'(id));
        chk("lit_rsp_result", 64'(rsp_result), 64'(res));
        chk("lit_rsp_zero", 64'(rsp_zero), 64'(z));
        chk("lit_rsp_isjr", 64'(rsp_isjr), 64'(j));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_rs = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_rs = '0; req1_shamt = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        req0_valid = 1'b1;
        #1;
        chk("lit_reset_ready0", 64'(req0_ready), 64'd0);
        chk("lit_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("lit_reset_alu_op", 64'(alu_op), 64'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single req0 add: 5 + 3.
        send(1'b0, 4'd3, 32'd5, 32'd3, 32'd0, 5'd0);
        wait_rsp(1'b0, 32'd8, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;

        // Simultaneous requests straight after reset: req0 first.
        do_reset();
        id_log.delete();
        fork
            send(1'b0, 4'd2, 32'd10, 32'd4, 32'd0, 5'd0);
            send(1'b1, 4'd3, 32'd1, 32'd1, 32'd0, 5'd0);
        join
        repeat (4) @(posedge clk);
        #2;
        chk("lit_tie_count", 64'(id_log.size()), 64'd2);
        if (id_log.size() == 2) begin
            chk("lit_tie_first", 64'(id_log[0]), 64'd0);
            chk("lit_tie_second", 64'(id_log[1]), 64'd1);
        end

        // Eight back-to-back operations with both requesters always valid.
        id_log.delete();
        hs_log.delete();
        fork
            for (int i = 0; i < 4; i++) send(1'b0, 4'd4, 32'd0, 32'(i + 1), 32'd0, 5'(i));
            for (int i = 0; i < 4; i++) send(1'b1, 4'd1, 32'(16 * i), 32'd3, 32'd0, 5'd0);
        join
        repeat (4) @(posedge clk);
        #2;
        chk("lit_rr_count", 64'(id_log.size()), 64'd8);
        for (int i = 0; i < id_log.size(); i++) chk("lit_rr_id", 64'(id_log[i]), 64'(i % 2));
        for (int i = 1; i < hs_log.size(); i++) chk("lit_rr_interval", 64'(hs_log[i] - hs_log[i-1]), 64'd3);

        // Pass-through of compare and jump-register style encodings.
        send(1'b1, 4'd8, 32'd7, 32'd0, 32'd7, 5'd0);
        wait_rsp(1'b1, 32'd7, 1'b1, 1'b0);
        send(1'b1, 4'd9, 32'h40, 32'd0, 32'd0, 5'd0);
        wait_rsp(1'b1, 32'h40, 1'b0, 1'b1);

        // Consumer stall while a new request waits.
        rsp_ready = 1'b0;
        send(1'b0, 4'd3, 32'd100, 32'd23, 32'd0, 5'd0);
        wait_rsp(1'b0, 32'd123, 1'b0, 1'b0);
        req0_op = 4'd2; req0_a = 32'd50; req0_b = 32'd8; req0_rs = '0; req0_shamt = '0;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_stall_ready0", 64'(req0_ready), 64'd0);
            chk("lit_stall_result", 64'(rsp_result), 64'd123);
            chk("lit_stall_valid", 64'(rsp_valid), 64'd1);
        end
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lit_after_stall_ready0", 64'(req0_ready), 64'd1);
        @(posedge clk);
        #2;
        req0_valid = 1'b0;
        wait_rsp(1'b0, 32'd42, 1'b0, 1'b0);

        // Reset while an operation is in ISSUE.
        send(1'b0, 4'd3, 32'h11, 32'h22, 32'd0, 5'd0);
        reset = 1'b0;
        #1;
        chk("lit_midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("lit_midreset_alu_a", 64'(alu_a), 64'd0);
        chk("lit_midreset_alu_op", 64'(alu_op), 64'd0);
        id_log.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("lit_midreset_no_rsp", 64'(id_log.size()), 64'd0);
        fork
            send(1'b1, 4'd0, 32'hF0, 32'h3C, 32'd0, 5'd0);
            send(1'b0, 4'd3, 32'd2, 32'd2, 32'd0, 5'd0);
        join
        repeat (4) @(posedge clk);
        #2;
        chk("lit_post_reset_count", 64'(id_log.size()), 64'd2);
        if (id_log.size() == 2) begin
            chk("lit_post_reset_first", 64'(id_log[0]), 64'd0);
            chk("lit_post_reset_second", 64'(id_log[1]), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
